// File: rtl/hex_counter_pkg.sv
// Shared types and helpers for the paced hex counter: speed-select encoding,
// divider period per speed, and the nibble width.
package hex_counter_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      SPD_FAST = 2'b00,
      SPD_1X   = 2'b01,
      SPD_2X   = 2'b10,
      SPD_4X   = 2'b11
   } speed_e;

   // Step period in clock cycles for a given speed select.
   function automatic int unsigned period(input speed_e speed, input int unsigned clk_hz);
      case (speed)
         SPD_FAST: period = 1;
         SPD_1X:   period = clk_hz;
         SPD_2X:   period = 2 * clk_hz;
         default:  period = 4 * clk_hz;
      endcase
   endfunction

endpackage

// File: rtl/rate_divider.sv
// Programmable rate divider: down-counts the selected period and raises a
// combinational step strobe when an enabled edge finds the counter at zero.
module rate_divider
   import hex_counter_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       load,
   input  logic [1:0] speed,
   output logic       step_c
);

   localparam int unsigned DIV_W = $clog2(4 * CLK_HZ);

   logic [DIV_W-1:0] div_q, div_d, reload;
   speed_e           speed_q, speed_d, speed_in;

   assign speed_in = speed_e'(speed);

   // Load and speed change both restart a full period; otherwise count down.
   always_comb begin
      reload  = DIV_W'(period(speed_in, CLK_HZ) - 1);
      div_d   = div_q;
      speed_d = speed_in;
      step_c  = 1'b0;
      if (load) begin
         div_d = reload;
      end else if (speed_in != speed_q) begin
         div_d = reload;
      end else if (enable) begin
         if (div_q == '0) begin
            step_c = 1'b1;
            div_d  = reload;
         end else begin
            div_d = div_q - DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q   <= '0;
         speed_q <= SPD_FAST;
      end else begin
         div_q   <= div_d;
         speed_q <= speed_d;
      end
   end

endmodule

// File: rtl/hex_rate_counter.sv
// Paced 4-bit hex counter feeding a 7-segment decoder digit.
// Define HEX_RATE_COUNTER_UPDOWN_EN to add the `up` direction input.
module hex_rate_counter
   import hex_counter_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [1:0]          speed,
   input  logic                load,
   input  logic [NIBBLE_W-1:0] load_value,
`ifdef HEX_RATE_COUNTER_UPDOWN_EN
   input  logic                up,
`endif
   output logic [NIBBLE_W-1:0] value,
   output logic                tick,
   output logic                wrap
);

   logic                step_c;
   logic                count_up_c;
   logic [NIBBLE_W-1:0] value_q, value_d;
   logic                tick_q, tick_d;
   logic                wrap_q, wrap_d;

   rate_divider #(
      .CLK_HZ (CLK_HZ)
   ) u_rate_divider (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .load   (load),
      .speed  (speed),
      .step_c (step_c)
   );

`ifdef HEX_RATE_COUNTER_UPDOWN_EN
   assign count_up_c = up;
`else
   assign count_up_c = 1'b1;
`endif

   // Load overrides a due step; the divider never strobes on a load edge.
   always_comb begin
      value_d = value_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      if (load) begin
         value_d = load_value;
      end else if (step_c) begin
         tick_d = 1'b1;
         if (count_up_c) begin
            value_d = value_q + NIBBLE_W'(1);
            wrap_d  = (value_q == '1);
         end else begin
            value_d = value_q - NIBBLE_W'(1);
            wrap_d  = (value_q == '0);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_q <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         value_q <= value_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
      end
   end

   assign value = value_q;
   assign tick  = tick_q;
   assign wrap  = wrap_q;

endmodule
